// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one memory bus between the data port (read/write) and
// the instruction-fetch port (read-only). Data has fixed priority over fetch.
// An anti-starvation counter hands the next arbitration to fetch after
// STARVE_LIMIT back-to-back data completions with fetch pending.
// A grant is locked while the slave holds rw_wait, so the slave-side address
// and write data stay stable for the whole transaction.
// Optional statistics counters are built when ARB_STATS_EN is defined.
//
// lock_owner states:
//   state     | meaning
//   OWN_NONE  | no transaction in flight, arbitrate this cycle
//   OWN_DATA  | data transaction waiting on the slave, grant held
//   OWN_FETCH | fetch transaction waiting on the slave, grant held
module bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        Nrst,
    input  logic [31:0] d_busaddr,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [31:0] d_wr_data,
    output logic        d_rw_wait,
    output logic [31:0] d_rd_data,
    input  logic [31:0] i_busaddr,
    input  logic        i_rd_req,
    output logic        i_rw_wait,
    output logic [31:0] i_rd_data,
    output logic [31:0] busaddr,
    output logic        rd_req,
    output logic        wr_req,
    output logic [31:0] wr_data,
    input  logic        rw_wait,
    input  logic [31:0] rd_data,
`ifdef ARB_STATS_EN
    input  logic        stat_clr,
    output logic [31:0] stat_dgrants,
    output logic [31:0] stat_igrants,
    output logic [31:0] stat_waits,
`endif
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'b00,
        OWN_DATA  = 2'b01,
        OWN_FETCH = 2'b10
    } own_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    own_t       lock_owner;
    own_t       grant;
    logic [3:0] starve_cnt;

    logic d_req;
    logic i_req;
    logic d_wr_eff;
    logic granted_req;
    logic d_done;
    logic i_done;

    // A simultaneous read and write on the data port is treated as a read.
    assign d_req    = d_rd_req | d_wr_req;
    assign i_req    = i_rd_req;
    assign d_wr_eff = d_wr_req & ~d_rd_req;

    // Grant: held owner first, otherwise data priority unless fetch is starved.
    always_comb begin
        grant = OWN_NONE;
        if (lock_owner != OWN_NONE) begin
            grant = lock_owner;
        end else if (i_req && (!d_req || starve_cnt == LIMIT)) begin
            grant = OWN_FETCH;
        end else if (d_req) begin
            grant = OWN_DATA;
        end
    end

    // Request of whichever port holds the grant; low on an abandoned lock.
    always_comb begin
        granted_req = 1'b0;
        case (grant)
            OWN_DATA:  granted_req = d_req;
            OWN_FETCH: granted_req = i_req;
            default:   granted_req = 1'b0;
        endcase
    end

    assign d_done = (grant == OWN_DATA)  && d_req && !rw_wait;
    assign i_done = (grant == OWN_FETCH) && i_req && !rw_wait;

    // Forward the granted port to the slave; stall the loser, hold all off in reset.
    always_comb begin
        busaddr   = 'x;
        wr_data   = 'x;
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        d_rw_wait = d_req;
        i_rw_wait = i_req;
        case (grant)
            OWN_DATA: begin
                busaddr   = d_busaddr;
                wr_data   = d_wr_data;
                rd_req    = d_rd_req;
                wr_req    = d_wr_eff;
                d_rw_wait = d_req & rw_wait;
            end
            OWN_FETCH: begin
                busaddr   = i_busaddr;
                rd_req    = i_rd_req;
                i_rw_wait = i_req & rw_wait;
            end
            default: ;
        endcase
        if (!Nrst) begin
            rd_req    = 1'b0;
            wr_req    = 1'b0;
            d_rw_wait = 1'b1;
            i_rw_wait = 1'b1;
        end
    end

    // Read data goes to both ports; only the granted, non-waiting one uses it.
    assign d_rd_data = rd_data;
    assign i_rd_data = rd_data;

    // Lock the grant while the slave waits; release on completion or abandon.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            lock_owner <= OWN_NONE;
        end else if (granted_req && rw_wait) begin
            lock_owner <= grant;
        end else begin
            lock_owner <= OWN_NONE;
        end
    end

    assign owner = lock_owner;

    // Count data completions that bypassed a pending fetch, saturating at the limit.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            starve_cnt <= 4'd0;
        end else if (!i_req || i_done) begin
            starve_cnt <= 4'd0;
        end else if (d_done && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

`ifdef ARB_STATS_EN
    logic any_wait;

    assign any_wait = (d_req & d_rw_wait) | (i_req & i_rw_wait);

    // Free-running completion and stall counters; a clear beats an increment.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            stat_dgrants <= 32'd0;
            stat_igrants <= 32'd0;
            stat_waits   <= 32'd0;
        end else if (stat_clr) begin
            stat_dgrants <= 32'd0;
            stat_igrants <= 32'd0;
            stat_waits   <= 32'd0;
        end else begin
            if (d_done)   stat_dgrants <= stat_dgrants + 32'd1;
            if (i_done)   stat_igrants <= stat_igrants + 32'd1;
            if (any_wait) stat_waits   <= stat_waits + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: single-cycle vector table through a
// scoreboard queue, plus hand-written multi-cycle sequences (wait lock,
// starvation rotation, abandon, reset mid-lock, optional statistics).
module tb_bus_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        Nrst;
    logic [31:0] d_busaddr;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [31:0] d_wr_data;
    logic        d_rw_wait;
    logic [31:0] d_rd_data;
    logic [31:0] i_busaddr;
    logic        i_rd_req;
    logic        i_rw_wait;
    logic [31:0] i_rd_data;
    logic [31:0] busaddr;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] wr_data;
    logic        rw_wait;
    logic [31:0] rd_data;
    logic [1:0]  owner;
`ifdef ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_dgrants;
    logic [31:0] stat_igrants;
    logic [31:0] stat_waits;
`endif

    always #5 clk = ~clk;

    bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk          (clk),
        .Nrst         (Nrst),
        .d_busaddr    (d_busaddr),
        .d_rd_req     (d_rd_req),
        .d_wr_req     (d_wr_req),
        .d_wr_data    (d_wr_data),
        .d_rw_wait    (d_rw_wait),
        .d_rd_data    (d_rd_data),
        .i_busaddr    (i_busaddr),
        .i_rd_req     (i_rd_req),
        .i_rw_wait    (i_rw_wait),
        .i_rd_data    (i_rd_data),
        .busaddr      (busaddr),
        .rd_req       (rd_req),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rw_wait      (rw_wait),
        .rd_data      (rd_data),
`ifdef ARB_STATS_EN
        .stat_clr     (stat_clr),
        .stat_dgrants (stat_dgrants),
        .stat_igrants (stat_igrants),
        .stat_waits   (stat_waits),
`endif
        .owner        (owner)
    );

    typedef struct {
        logic        d_rd;
        logic        d_wr;
        logic [31:0] d_addr;
        logic [31:0] d_wd;
        logic        i_rd;
        logic [31:0] i_addr;
        logic        rw;
        logic [31:0] rdat;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_dw;
        logic        e_iw;
        logic [1:0]  e_own;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];
    vec_t sb[$];
    logic [1:0] win_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive(input logic drd, input logic dwr, input logic [31:0] da,
                         input logic [31:0] dwd, input logic ird, input logic [31:0] ia,
                         input logic rw, input logic [31:0] rdat);
        d_rd_req  = drd;
        d_wr_req  = dwr;
        d_busaddr = da;
        d_wr_data = dwd;
        i_rd_req  = ird;
        i_busaddr = ia;
        rw_wait   = rw;
        rd_data   = rdat;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0);
        next();
    endtask

    // Continuous contention with no slave waits; expected winner per cycle
    // follows the D^LIMIT,I rotation starting from a cleared starve count.
    task automatic winner_seq(input string tag, input int ncyc);
        logic [1:0] act;
        logic [1:0] exp;
        for (int k = 0; k < ncyc; k++) begin
            drive(1, 0, 32'hD000, 32'h0, 1, 32'h1000, 0, 32'h0);
            win_q.push_back((k % (STARVE_LIMIT + 1) == STARVE_LIMIT) ? 2'b10 : 2'b01);
            @(negedge clk);
            if (rd_req && busaddr == 32'h1000 && !i_rw_wait && d_rw_wait)      act = 2'b10;
            else if (rd_req && busaddr == 32'hD000 && !d_rw_wait && i_rw_wait) act = 2'b01;
            else                                                               act = 2'b11;
            exp = win_q.pop_front();
            chk($sformatf("%s_winner_%0d", tag, k), {30'b0, act}, {30'b0, exp});
            next();
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic stat_op(input logic drd, input logic dwr, input logic ird, input int waits);
        for (int c = 0; c <= waits; c++) begin
            drive(drd, dwr, 32'h900, 32'h77, ird, 32'h120, (c < waits), 32'h0);
            next();
        end
        idle_cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t e;
        //           d_rd d_wr d_addr        d_wd          i_rd i_addr      rw rdat           e_rd e_wr e_addr       e_wd          e_dw e_iw e_own
        vecs[0] = '{0, 0, 32'h0,      32'h0,        0, 32'h0,     0, 32'h11111111, 0, 0, 32'h0,      32'h0,        0, 0, 2'b00};
        vecs[1] = '{0, 0, 32'h0,      32'h0,        1, 32'h100,   0, 32'hE3A00001, 1, 0, 32'h100,    32'h0,        0, 0, 2'b00};
        vecs[2] = '{1, 0, 32'h300,    32'h0,        0, 32'h100,   0, 32'hCAFEF00D, 1, 0, 32'h300,    32'h0,        0, 0, 2'b00};
        vecs[3] = '{0, 1, 32'h2000,   32'hDEADBEEF, 0, 32'h0,     0, 32'h0,        0, 1, 32'h2000,   32'hDEADBEEF, 0, 0, 2'b00};
        vecs[4] = '{1, 1, 32'h400,    32'h55AA55AA, 0, 32'h0,     0, 32'h12345678, 1, 0, 32'h400,    32'h0,        0, 0, 2'b00};
        vecs[5] = '{1, 0, 32'h500,    32'h0,        1, 32'h104,   0, 32'hA5A5A5A5, 1, 0, 32'h500,    32'h0,        0, 1, 2'b00};
        vecs[6] = '{0, 1, 32'h600,    32'h0BADF00D, 1, 32'h108,   0, 32'h0,        0, 1, 32'h600,    32'h0BADF00D, 0, 1, 2'b00};
        vecs[7] = '{0, 0, 32'h0,      32'h0,        1, 32'h10C,   1, 32'h0,        1, 0, 32'h10C,    32'h0,        0, 1, 2'b10};
        vecs[8] = '{1, 0, 32'h700,    32'h0,        0, 32'h0,     1, 32'h0,        1, 0, 32'h700,    32'h0,        1, 0, 2'b01};
        vecs[9] = '{1, 0, 32'h800,    32'h0,        1, 32'h110,   1, 32'h0,        1, 0, 32'h800,    32'h0,        1, 1, 2'b01};

        // Reset state with both ports requesting.
        Nrst = 1'b0;
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        drive(1, 1, 32'h40, 32'h1, 1, 32'h80, 0, 32'h0);
        #3;
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_wr_req", wr_req, 1'b0);
        chk("rst_d_wait", d_rw_wait, 1'b1);
        chk("rst_i_wait", i_rw_wait, 1'b1);
        chk("rst_owner", owner, 2'b00);
        next();
        Nrst = 1'b1;
        idle_cycle();

        // Single-cycle vector table.
        for (int k = 0; k < NV; k++) begin
            drive(vecs[k].d_rd, vecs[k].d_wr, vecs[k].d_addr, vecs[k].d_wd,
                  vecs[k].i_rd, vecs[k].i_addr, vecs[k].rw, vecs[k].rdat);
            sb.push_back(vecs[k]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d_rd_req", k), rd_req, e.e_rd);
            chk($sformatf("v%0d_wr_req", k), wr_req, e.e_wr);
            if (e.e_rd || e.e_wr) chk($sformatf("v%0d_busaddr", k), busaddr, e.e_addr);
            if (e.e_wr)           chk($sformatf("v%0d_wr_data", k), wr_data, e.e_wd);
            chk($sformatf("v%0d_d_wait", k), d_rw_wait, e.e_dw);
            chk($sformatf("v%0d_i_wait", k), i_rw_wait, e.e_iw);
            chk($sformatf("v%0d_d_rd_data", k), d_rd_data, e.rdat);
            chk($sformatf("v%0d_i_rd_data", k), i_rd_data, e.rdat);
            chk($sformatf("v%0d_owner_pre", k), owner, 2'b00);
            next();
            chk($sformatf("v%0d_owner_post", k), owner, e.e_own);
            idle_cycle();
        end

        // Contended write held through two slave wait cycles.
        for (int c = 0; c < 3; c++) begin
            drive(0, 1, 32'h2000, 32'hDEADBEEF, 1, 32'h100, (c < 2), 32'h0);
            @(negedge clk);
            chk($sformatf("lock%0d_wr_req", c), wr_req, 1'b1);
            chk($sformatf("lock%0d_busaddr", c), busaddr, 32'h2000);
            chk($sformatf("lock%0d_wr_data", c), wr_data, 32'hDEADBEEF);
            chk($sformatf("lock%0d_i_wait", c), i_rw_wait, 1'b1);
            chk($sformatf("lock%0d_d_wait", c), d_rw_wait, (c < 2));
            chk($sformatf("lock%0d_owner", c), owner, (c == 0) ? 2'b00 : 2'b01);
            next();
        end
        drive(0, 0, 32'h2000, 32'h0, 1, 32'h100, 0, 32'h0);
        @(negedge clk);
        chk("lock_after_busaddr", busaddr, 32'h100);
        chk("lock_after_rd_req", rd_req, 1'b1);
        chk("lock_after_i_wait", i_rw_wait, 1'b0);
        chk("lock_after_owner", owner, 2'b00);
        next();
        idle_cycle();

        // Starvation rotation D,D,D,D,I repeating.
        winner_seq("starve", 3 * (STARVE_LIMIT + 1));
        idle_cycle();

        // Abandon a locked fetch while data is pending.
        drive(0, 0, 32'h0, 32'h0, 1, 32'h100, 1, 32'h0);
        @(negedge clk);
        chk("ab_fetch_rd_req", rd_req, 1'b1);
        chk("ab_fetch_busaddr", busaddr, 32'h100);
        chk("ab_fetch_i_wait", i_rw_wait, 1'b1);
        next();
        chk("ab_owner_fetch", owner, 2'b10);
        drive(1, 0, 32'h300, 32'h0, 1, 32'h100, 1, 32'h0);
        @(negedge clk);
        chk("ab_nopreempt_busaddr", busaddr, 32'h100);
        chk("ab_nopreempt_d_wait", d_rw_wait, 1'b1);
        next();
        chk("ab_owner_held", owner, 2'b10);
        drive(1, 0, 32'h300, 32'h0, 0, 32'h100, 1, 32'h0);
        @(negedge clk);
        chk("ab_drop_rd_req", rd_req, 1'b0);
        chk("ab_drop_d_wait", d_rw_wait, 1'b1);
        chk("ab_drop_i_wait", i_rw_wait, 1'b0);
        next();
        chk("ab_owner_none", owner, 2'b00);
        drive(1, 0, 32'h300, 32'h0, 0, 32'h100, 0, 32'h0);
        @(negedge clk);
        chk("ab_data_busaddr", busaddr, 32'h300);
        chk("ab_data_rd_req", rd_req, 1'b1);
        chk("ab_data_d_wait", d_rw_wait, 1'b0);
        next();
        idle_cycle();

        // Reset mid-lock with starve count primed to LIMIT-1.
        winner_seq("prime", STARVE_LIMIT - 1);
        drive(1, 0, 32'hD000, 32'h0, 1, 32'h1000, 1, 32'h0);
        @(negedge clk);
        chk("rml_grant_data", busaddr, 32'hD000);
        next();
        chk("rml_owner_data", owner, 2'b01);
        #2;
        Nrst = 1'b0;
        #1;
        chk("rml_rd_req", rd_req, 1'b0);
        chk("rml_wr_req", wr_req, 1'b0);
        chk("rml_d_wait", d_rw_wait, 1'b1);
        chk("rml_i_wait", i_rw_wait, 1'b1);
        chk("rml_owner", owner, 2'b00);
        rw_wait = 1'b0;
        next();
        Nrst = 1'b1;
        winner_seq("postrst", STARVE_LIMIT + 1);
        idle_cycle();

`ifdef ARB_STATS_EN
        stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        stat_op(1, 0, 0, 2);
        stat_op(1, 0, 0, 0);
        stat_op(0, 1, 0, 1);
        stat_op(0, 0, 1, 2);
        stat_op(0, 0, 1, 0);
        chk("stat_dgrants", stat_dgrants, 32'd3);
        chk("stat_igrants", stat_igrants, 32'd2);
        chk("stat_waits", stat_waits, 32'd5);
        drive(1, 0, 32'h900, 32'h0, 0, 32'h0, 0, 32'h0);
        stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        chk("stat_clr_dgrants", stat_dgrants, 32'd0);
        chk("stat_clr_igrants", stat_igrants, 32'd0);
        chk("stat_clr_waits", stat_waits, 32'd0);
        idle_cycle();
        stat_op(1, 0, 0, 0);
        chk("stat_resume_dgrants", stat_dgrants, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
